pid_chk_seq: RTL

Parametrised successor to the USB receive-path PID checker.
- Validates each received PID byte and classifies the packet as token, data or handshake.
- Drives data_select and the CRC5/CRC16 engine enables for the packet body.
- Counts payload bytes and checks packet length against the PID type.
- Tracks the DATA0/DATA1 toggle per endpoint across NUM_EP endpoints, flagging sequence errors.
- Sits between the byte de-serialiser/EOP detector and the CRC checkers and receive FIFO.

---
 rtl/pid_chk_pkg.sv | 51 +++++
 rtl/ep_toggle_bank.sv | 39 +++
 rtl/pid_chk_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pid_chk_pkg.sv
// Shared definitions for the USB receive-path PID checker: PID codes,
// data_select encoding, FSM states and the PID classification helpers.
package pid_chk_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [1:0] DSEL_IDLE  = 2'b00;
    localparam logic [1:0] DSEL_TOKEN = 2'b01;
    localparam logic [1:0] DSEL_DATA  = 2'b10;
    localparam logic [1:0] DSEL_HSHK  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TOKEN = 3'd1,
        ST_DATA  = 3'd2,
        ST_HSHK  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_INVALID = 2'd0,
        CLS_TOKEN   = 2'd1,
        CLS_DATA    = 2'd2,
        CLS_HSHK    = 2'd3
    } pid_cls_t;

    // Upper nibble of a PID byte carries the one's complement of the code.
    function automatic logic pid_check_ok(input logic [7:0] pid);
        return (pid[7:4] == ~pid[3:0]);
    endfunction

    function automatic pid_cls_t pid_class(input logic [3:0] code);
        pid_cls_t cls;
        case (code)
            PID_OUT, PID_IN, PID_SOF, PID_SETUP: cls = CLS_TOKEN;
            PID_DATA0, PID_DATA1:                cls = CLS_DATA;
            PID_ACK, PID_NAK, PID_STALL:         cls = CLS_HSHK;
            default:                             cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/ep_toggle_bank.sv
// Per-endpoint DATA0/DATA1 expected-toggle flops; clear has priority over flip.
module ep_toggle_bank #(
    parameter int NUM_EP    = 4,
    parameter int EP_ADDR_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 flip,
    input  logic [EP_ADDR_W-1:0] idx,
    output logic [NUM_EP-1:0]    toggle
);

    logic [NUM_EP-1:0] toggle_r;

    // Toggle state per endpoint, updated only for the selected index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle_r <= {NUM_EP{1'b0}};
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (int'(idx) == i) begin
                    if (clr) begin
                        toggle_r[i] <= 1'b0;
                    end else if (flip) begin
                        toggle_r[i] <= ~toggle_r[i];
                    end else begin
                        toggle_r[i] <= toggle_r[i];
                    end
                end else begin
                    toggle_r[i] <= toggle_r[i];
                end
            end
        end
    end

    assign toggle = toggle_r;

endmodule

// File: rtl/pid_chk_seq.sv
// USB receive-path PID checker: validates/classifies PIDs, drives CRC enables,
// checks body length per PID type and tracks per-endpoint data toggles.
module pid_chk_seq
    import pid_chk_pkg::*;
#(
    parameter int NUM_EP    = 4,
    parameter int EP_ADDR_W = 2,
    parameter int MAX_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 PID_enable,
    input  logic [7:0]           PID_I,
    input  logic [EP_ADDR_W-1:0] ep_sel,
    input  logic                 byte_valid,
    input  logic                 EOP_flag,
    input  logic                 crc_ok,
    output logic [1:0]           data_select,
    output logic                 crc5_enable,
    output logic                 crc16_enable,
    output logic [3:0]           pid_type,
    output logic                 pkt_done,
    output logic                 pid_err,
    output logic                 len_err,
    output logic                 seq_err,
    output logic [NUM_EP-1:0]    expected_toggle
);

    localparam int CNT_MAX = MAX_BYTES + 3;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t               state_r, state_nxt_s;
    logic [CNT_W-1:0]     cnt_r, cnt_nxt_s, cnt_inc_s, eval_cnt_s;
    logic [EP_ADDR_W-1:0] ep_r, ep_nxt_s;
    logic                 zlp_r, zlp_nxt_s;
    logic [3:0]           pid_type_nxt_s;
    logic [1:0]           dsel_nxt_s;
    logic                 crc5_nxt_s, crc16_nxt_s;
    logic                 pkt_done_nxt_s, pid_err_nxt_s, len_err_nxt_s, seq_err_nxt_s;
    logic                 eval_s, clr_s, flip_s, ep_valid_s, tog_sel_s;
    pid_cls_t             cls_s;

    // Expected toggle of the latched endpoint, with out-of-range endpoints excluded.
    always_comb begin
        ep_valid_s = (int'(ep_r) < NUM_EP);
        tog_sel_s  = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (int'(ep_r) == i) begin
                tog_sel_s = expected_toggle[i];
            end else begin
                tog_sel_s = tog_sel_s;
            end
        end
    end

    // Next-state, packet evaluation and next-output logic.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        ep_nxt_s       = ep_r;
        zlp_nxt_s      = 1'b0;
        pid_type_nxt_s = pid_type;
        pkt_done_nxt_s = 1'b0;
        pid_err_nxt_s  = 1'b0;
        len_err_nxt_s  = 1'b0;
        seq_err_nxt_s  = 1'b0;
        clr_s          = 1'b0;
        flip_s         = 1'b0;
        eval_s         = 1'b0;
        eval_cnt_s     = cnt_r;
        cls_s          = pid_class(PID_I[3:0]);
        cnt_inc_s      = (cnt_r == CNT_W'(CNT_MAX)) ? cnt_r : (cnt_r + CNT_W'(1));

        case (state_r)
            ST_IDLE: begin
                if (PID_enable) begin
                    if (!pid_check_ok(PID_I) || (cls_s == CLS_INVALID)) begin
                        pid_err_nxt_s = 1'b1;
                        state_nxt_s   = EOP_flag ? ST_IDLE : ST_ERR;
                    end else begin
                        ep_nxt_s       = ep_sel;
                        pid_type_nxt_s = PID_I[3:0];
                        cnt_nxt_s      = {CNT_W{1'b0}};
                        // Zero-length packet: evaluate on the following cycle.
                        zlp_nxt_s      = EOP_flag;
                        case (cls_s)
                            CLS_TOKEN: state_nxt_s = ST_TOKEN;
                            CLS_DATA:  state_nxt_s = ST_DATA;
                            CLS_HSHK:  state_nxt_s = ST_HSHK;
                            default:   state_nxt_s = ST_ERR;
                        endcase
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TOKEN, ST_DATA, ST_HSHK: begin
                if (zlp_r) begin
                    eval_s     = 1'b1;
                    eval_cnt_s = {CNT_W{1'b0}};
                end else if (EOP_flag) begin
                    eval_s     = 1'b1;
                    eval_cnt_s = byte_valid ? cnt_inc_s : cnt_r;
                end else if (PID_enable) begin
                    pid_err_nxt_s = 1'b1;
                    state_nxt_s   = ST_ERR;
                end else if (byte_valid) begin
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_ERR: begin
                if (EOP_flag) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ERR;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        if (eval_s) begin
            state_nxt_s    = ST_IDLE;
            cnt_nxt_s      = {CNT_W{1'b0}};
            pkt_done_nxt_s = 1'b1;
            case (state_r)
                ST_TOKEN: begin
                    len_err_nxt_s = (eval_cnt_s != CNT_W'(2));
                    clr_s = ep_valid_s && (pid_type == PID_SETUP) && (eval_cnt_s == CNT_W'(2));
                end
                ST_DATA: begin
                    len_err_nxt_s = (eval_cnt_s < CNT_W'(2)) ||
                                    (eval_cnt_s > CNT_W'(MAX_BYTES + 2));
                    seq_err_nxt_s = ep_valid_s && (pid_type[3] != tog_sel_s);
                    // A CRC failure leaves the toggle alone and is reported elsewhere.
                    flip_s = ep_valid_s && (pid_type[3] == tog_sel_s) && crc_ok && !len_err_nxt_s;
                end
                ST_HSHK: len_err_nxt_s = (eval_cnt_s != CNT_W'(0));
                default: pkt_done_nxt_s = 1'b0;
            endcase
        end else begin
            pkt_done_nxt_s = 1'b0;
        end

        case (state_nxt_s)
            ST_TOKEN: begin dsel_nxt_s = DSEL_TOKEN; crc5_nxt_s = 1'b1; crc16_nxt_s = 1'b0; end
            ST_DATA:  begin dsel_nxt_s = DSEL_DATA;  crc5_nxt_s = 1'b0; crc16_nxt_s = 1'b1; end
            ST_HSHK:  begin dsel_nxt_s = DSEL_HSHK;  crc5_nxt_s = 1'b0; crc16_nxt_s = 1'b0; end
            default:  begin dsel_nxt_s = DSEL_IDLE;  crc5_nxt_s = 1'b0; crc16_nxt_s = 1'b0; end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            ep_r         <= {EP_ADDR_W{1'b0}};
            zlp_r        <= 1'b0;
            pid_type     <= 4'b0000;
            data_select  <= DSEL_IDLE;
            crc5_enable  <= 1'b0;
            crc16_enable <= 1'b0;
            pkt_done     <= 1'b0;
            pid_err      <= 1'b0;
            len_err      <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ep_r         <= ep_nxt_s;
            zlp_r        <= zlp_nxt_s;
            pid_type     <= pid_type_nxt_s;
            data_select  <= dsel_nxt_s;
            crc5_enable  <= crc5_nxt_s;
            crc16_enable <= crc16_nxt_s;
            pkt_done     <= pkt_done_nxt_s;
            pid_err      <= pid_err_nxt_s;
            len_err      <= len_err_nxt_s;
            seq_err      <= seq_err_nxt_s;
        end
    end

    ep_toggle_bank #(
        .NUM_EP    (NUM_EP),
        .EP_ADDR_W (EP_ADDR_W)
    ) u_toggle_bank (
        .clk    (clk),
        .rst_n  (rst),
        .clr    (clr_s),
        .flip   (flip_s),
        .idx    (ep_r),
        .toggle (expected_toggle)
    );

endmodule
